// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: registered divided clocks plus one-cycle enable strobes.
// Divisor changes apply at period boundaries (or immediately while a channel is disabled).
module clk_div_prog #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       div_load_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH*CNT_W-1:0] div_active_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  // Divisors below 2 cannot form a high and a low phase.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_new;
    logic [CNT_W-1:0] div_last;
    logic [CNT_W-1:0] cnt_inc;
    logic             wrap;

    assign div_new  = clamp_div(div_i[c*CNT_W +: CNT_W]);
    assign div_last = div_q - ONE;
    assign cnt_inc  = cnt_q + ONE;
    assign wrap     = en_i[c] && (cnt_q == div_last);

    always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;
      if (!en_i[c]) begin
        // Park on the last count so the first enabled cycle wraps and rises.
        clk_d      = 1'b0;
        pend_vld_d = 1'b0;
        cnt_d      = div_last;
        if (div_load_i[c]) begin
          div_d = div_new;
          cnt_d = div_new - ONE;
        end else if (pend_vld_q) begin
          div_d = pend_q;
          cnt_d = pend_q - ONE;
        end
      end else if (wrap) begin
        cnt_d      = '0;
        clk_d      = 1'b1;
        tick_d     = 1'b1;
        pend_vld_d = 1'b0;
        if (div_load_i[c]) begin
          div_d = div_new;
        end else if (pend_vld_q) begin
          div_d = pend_q;
        end
      end else begin
        cnt_d = cnt_inc;
        clk_d = (cnt_inc < (div_q >> 1));
        if (div_load_i[c]) begin
          pend_d     = div_new;
          pend_vld_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n) begin
        cnt_q      <= DIV_RST - ONE;
        div_q      <= DIV_RST;
        pend_q     <= DIV_RST;
        pend_vld_q <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_q      <= div_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_o[c]                      = clk_q;
    assign tick_o[c]                     = tick_q;
    assign div_active_o[c*CNT_W +: CNT_W] = div_q;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Multi-channel programmable clock divider. It generates flop-driven divided clocks (clk_o) and single-cycle clock-enable strobes (tick_o) from one fabric clock. It supplies the SoC core clock, UART baud and peripheral strobes.
Each channel has its own divisor, changeable at runtime. A change takes effect only at a period boundary, so no runt periods come from reprogramming.

Parameters:
NUM_CH, 2, number of independent divider channels
CNT_W, 16, counter/divisor width; max divisor 2^CNT_W-1
DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be >=2)

Ports:
clk_i  input  1  fabric clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
en_i  input  NUM_CH  per-channel run enable
div_i  input  NUM_CH*CNT_W  requested divisor; channel c uses bits [c*CNT_W +: CNT_W]
div_load_i  input  NUM_CH  per-channel one-cycle strobe; captures the matching div_i slice
clk_o  output  NUM_CH  divided clock, registered
tick_o  output  NUM_CH  one-cycle pulse, coincident with each rising edge of clk_o
div_active_o  output  NUM_CH*CNT_W  divisor currently in effect per channel

Behaviour:
- Interface: one clock, clk_i; reset_n is synchronous and active-low, sampled on the clk_i rising edge.
- Per-channel state: cnt[CNT_W], div_q[CNT_W], pend[CNT_W], pend_v, clk_o, tick_o. Channels are fully independent.
- Reset (reset_n=0 at an edge): div_q=DEFAULT_DIV, cnt=DEFAULT_DIV-1, pend_v=0, clk_o=0, tick_o=0. Reset mid-operation discards pending loads and the current period.
- Clamp rule: any loaded divisor <2 becomes 2. Applies to div_i values 0 and 1.
- Wrap condition: en_i=1 and cnt==div_q-1.
- On wrap:
  - cnt<=0, clk_o<=1, tick_o<=1.
  - div_q<=new divisor if one is available, else unchanged.
  - Load priority: div_load_i this cycle (bypass) > pend if pend_v > no change.
  - pend_v<=0.
- On en_i=1 without wrap: cnt<=cnt+1; clk_o<=((cnt+1) < (div_q>>1)); tick_o<=0.
- Resulting waveform:
  - Period is div_q cycles.
  - High phase is floor(div_q/2) cycles, starting at the wrap; low phase is the rest.
  - D=2 gives exact 50%. Odd D is high-short (D=3: 1 high, 2 low).
- On en_i=0:
  - cnt<=div_q-1, clk_o<=0, tick_o<=0.
  - If pend_v=1 or div_load_i=1: div_q<=clamped new value immediately and pend_v<=0; cnt<=new div_q-1.
  - Channel restarts so the first cycle with en_i=1 produces a wrap (rising edge).
  - Truncating a high phase on disable is permitted; clk_o never pulses for less than one clk_i cycle.
- div_load_i with en_i=1 and no wrap: pend<=clamp(div_i slice), pend_v<=1. A second load before the boundary overwrites pend (last writer wins).
- Latency:
  - tick_o/clk_o rise one edge after the wrap-condition edge is evaluated; the first rise appears the first cycle en_i=1 after reset.
  - div_active_o = div_q; it updates at the same edge as the rising clk_o that starts the new period.
- Counter never exceeds div_q-1. No arithmetic overflow, since div_q <= 2^CNT_W-1.
- All outputs are direct flop outputs; there is no combinational path from inputs to outputs.

Test Plan:
- Reset 3 cycles, release with en_i=all 1s, DEFAULT_DIV=2 -> each clk_o reads 1,0,1,0… starting first cycle after release; tick_o=1 on cycles 0,2,4; div_active_o=2.
- Ch0 at D=2, pulse div_load_i[0] with div_i=5 on the low-phase cycle -> current period ends at length 2; then repeating 1,1,0,0,0 with tick every 5 cycles; div_active_o[0] becomes 5 at the new rise; ch1 unaffected.
- Load div_i=0 then (separately) 1 -> div_active_o=2 after the next boundary; waveform identical to D=2.
- Ch0 D=4, drop en_i[0] on 2nd high cycle -> clk_o[0]=0 and tick_o[0]=0 next edge; load D=3 while disabled -> div_active_o=3 immediately; re-enable -> rise on first enabled cycle, then pattern 1,0,0.
- div_load_i[1] (D=7) asserted on exactly the wrap cycle of ch1 (D=3) -> the period starting at that wrap is 7 cycles, high 3; no intermediate D=3 period.
- Ch0 D=6 running, reset_n=0 for one cycle mid-high phase with a pending load -> next edge clk_o=0, tick_o=0, div_active_o=DEFAULT_DIV; the pending value is never applied.
